// File: rtl/decode_stage.sv
// decode_stage: RV32I/RV64I subset decoder feeding a DEPTH-entry valid/ready
// queue of decoded fields, with a saturating count of accepted illegal words.
module decode_stage #(
  parameter int XLEN      = 32,
  parameter int DEPTH     = 2,
  parameter int M_EN      = 1,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 flush_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [31:0]          instruction_i,
  input  logic [XLEN-1:0]      pc_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [XLEN-1:0]      pc_o,
  output logic [6:0]           opcode_o,
  output logic [4:0]           rs1_o,
  output logic [4:0]           rs2_o,
  output logic [4:0]           rd_o,
  output logic [2:0]           funct3_o,
  output logic [6:0]           funct7_o,
  output logic                 rf_rw_o,
  output logic                 err_o,
  output logic [XLEN-1:0]      immediate_o,
  output logic [ERR_CNT_W-1:0] err_cnt_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [6:0]      opcode;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic            rf_rw;
    logic            err;
    logic [XLEN-1:0] imm;
  } entry_t;

  // Every immediate format is first assembled as a 32-bit signed value, then
  // widened; this avoids zero-width replications when XLEN is 32.
  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    return XLEN'($signed(v));
  endfunction

  logic [6:0] opc;
  logic [2:0] f3;
  logic [6:0] f7;
  logic [4:0] f_rs1, f_rs2, f_rd;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_j, imm_u;

  assign opc   = instruction_i[6:0];
  assign f3    = instruction_i[14:12];
  assign f7    = instruction_i[31:25];
  assign f_rs1 = instruction_i[19:15];
  assign f_rs2 = instruction_i[24:20];
  assign f_rd  = instruction_i[11:7];

  assign imm_i = sext32({{20{instruction_i[31]}}, instruction_i[31:20]});
  assign imm_s = sext32({{20{instruction_i[31]}}, instruction_i[31:25], instruction_i[11:7]});
  assign imm_b = sext32({{19{instruction_i[31]}}, instruction_i[31], instruction_i[7],
                         instruction_i[30:25], instruction_i[11:8], 1'b0});
  assign imm_j = sext32({{11{instruction_i[31]}}, instruction_i[31], instruction_i[19:12],
                         instruction_i[20], instruction_i[30:21], 1'b0});
  assign imm_u = sext32({instruction_i[31:12], 12'b0});

  entry_t dec;
  logic   legal;

  // Combinational decode of the incoming word into the entry that gets queued.
  always_comb begin
    // NOTE: every field gets a default before the case so no path leaves a
    // signal unassigned, which would otherwise infer a latch.
    dec        = '0;
    dec.pc     = pc_i;
    dec.opcode = opc;
    legal      = 1'b1;
    case (opc)
      OPC_OP: begin
        if ((f7 == 7'b0000000 && (f3 == 3'b000 || f3 == 3'b100)) ||
            (M_EN != 0 && f7 == 7'b0000001 && f3 == 3'b000)) begin
          dec.rs1    = f_rs1;
          dec.rs2    = f_rs2;
          dec.rd     = f_rd;
          dec.funct3 = f3;
          dec.funct7 = f7;
          dec.rf_rw  = 1'b1;
        end else begin
          legal = 1'b0;
        end
      end
      OPC_OP_IMM, OPC_LOAD, OPC_JALR: begin
        if ((opc == OPC_LOAD && f3 == 3'b010) || (opc != OPC_LOAD && f3 == 3'b000)) begin
          dec.rs1    = f_rs1;
          dec.rd     = f_rd;
          dec.funct3 = f3;
          dec.rf_rw  = 1'b1;
          dec.imm    = imm_i;
        end else begin
          legal = 1'b0;
        end
      end
      OPC_STORE: begin
        if (f3 == 3'b010) begin
          dec.rs1    = f_rs1;
          dec.rs2    = f_rs2;
          dec.funct3 = f3;
          dec.imm    = imm_s;
        end else begin
          legal = 1'b0;
        end
      end
      OPC_BRANCH: begin
        if (f3 == 3'b000 || f3 == 3'b001) begin
          dec.rs1    = f_rs1;
          dec.rs2    = f_rs2;
          dec.funct3 = f3;
          dec.imm    = imm_b;
        end else begin
          legal = 1'b0;
        end
      end
      OPC_JAL: begin
        dec.rd    = f_rd;
        dec.rf_rw = 1'b1;
        dec.imm   = imm_j;
      end
      OPC_LUI, OPC_AUIPC: begin
        dec.rd    = f_rd;
        dec.rf_rw = 1'b1;
        dec.imm   = imm_u;
      end
      default: legal = 1'b0;
    endcase

    if (!legal) begin
      dec        = '0;
      dec.pc     = pc_i;
      dec.opcode = opc;
      dec.err    = 1'b1;
    end
    if (dec.rd == 5'd0) dec.rf_rw = 1'b0;
  end

  entry_t                 mem [DEPTH];
  logic [PTR_W-1:0]       wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]         count_q;
  logic [ERR_CNT_W-1:0]   err_cnt_q;
  logic                   full, empty, push, pop;
  entry_t                 head;

  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);
  assign push  = in_valid_i && !full && !flush_i;
  assign pop   = !empty && out_ready_i && !flush_i;

  // Pointer, occupancy and illegal-counter state; flush empties but keeps the count.
  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst_i) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      err_cnt_q <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + (PTR_W + 1)'(1);
        2'b01:   count_q <= count_q - (PTR_W + 1)'(1);
        default: count_q <= count_q;
      endcase
      if (push && dec.err && err_cnt_q != '1) err_cnt_q <= err_cnt_q + ERR_CNT_W'(1);
    end
  end

  // Entry storage, written on push only.
  always_ff @(posedge clk_i) begin
    // NOTE: the storage array is not reset; occupancy is, and the head mux
    // below masks stale contents whenever the queue is empty.
    if (push) mem[wr_ptr_q] <= dec;
  end

  assign head = empty ? '0 : mem[rd_ptr_q];

  assign in_ready_o  = !full;
  assign out_valid_o = !empty;
  assign pc_o        = head.pc;
  assign opcode_o    = head.opcode;
  assign rs1_o       = head.rs1;
  assign rs2_o       = head.rs2;
  assign rd_o        = head.rd;
  assign funct3_o    = head.funct3;
  assign funct7_o    = head.funct7;
  assign rf_rw_o     = head.rf_rw;
  assign err_o       = head.err;
  assign immediate_o = head.imm;
  assign err_cnt_o   = err_cnt_q;

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed bench for decode_stage. Two instances share the
// stimulus: d32 (XLEN=32, M_EN=1) and d64 (XLEN=64, M_EN=0), both DEPTH=2.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] instr = '0;
  logic [31:0] pc32 = '0;
  logic [63:0] pc64;

  assign pc64 = {32'hA5A5_A5A5, pc32};

  logic        d32_in_ready, d32_out_valid, d32_rf_rw, d32_err;
  logic [31:0] d32_pc, d32_imm;
  logic [6:0]  d32_opcode, d32_funct7;
  logic [4:0]  d32_rs1, d32_rs2, d32_rd;
  logic [2:0]  d32_funct3;
  logic [7:0]  d32_err_cnt;

  logic        d64_in_ready, d64_out_valid, d64_rf_rw, d64_err;
  logic [63:0] d64_pc, d64_imm;
  logic [6:0]  d64_opcode, d64_funct7;
  logic [4:0]  d64_rs1, d64_rs2, d64_rd;
  logic [2:0]  d64_funct3;
  logic [7:0]  d64_err_cnt;

  // {opcode, rs1, rs2, rd, funct3, funct7, rf_rw, err}
  logic [33:0] f32, f64;
  assign f32 = {d32_opcode, d32_rs1, d32_rs2, d32_rd, d32_funct3, d32_funct7, d32_rf_rw, d32_err};
  assign f64 = {d64_opcode, d64_rs1, d64_rs2, d64_rd, d64_funct3, d64_funct7, d64_rf_rw, d64_err};

  int checks = 0;
  int errors = 0;

  decode_stage #(.XLEN(32), .DEPTH(2), .M_EN(1), .ERR_CNT_W(8)) d32 (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(d32_in_ready),
    .instruction_i(instr), .pc_i(pc32), .out_valid_o(d32_out_valid), .out_ready_i(out_ready),
    .pc_o(d32_pc), .opcode_o(d32_opcode), .rs1_o(d32_rs1), .rs2_o(d32_rs2), .rd_o(d32_rd),
    .funct3_o(d32_funct3), .funct7_o(d32_funct7), .rf_rw_o(d32_rf_rw), .err_o(d32_err),
    .immediate_o(d32_imm), .err_cnt_o(d32_err_cnt)
  );

  decode_stage #(.XLEN(64), .DEPTH(2), .M_EN(0), .ERR_CNT_W(8)) d64 (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(d64_in_ready),
    .instruction_i(instr), .pc_i(pc64), .out_valid_o(d64_out_valid), .out_ready_i(out_ready),
    .pc_o(d64_pc), .opcode_o(d64_opcode), .rs1_o(d64_rs1), .rs2_o(d64_rs2), .rd_o(d64_rd),
    .funct3_o(d64_funct3), .funct7_o(d64_funct7), .rf_rw_o(d64_rf_rw), .err_o(d64_err),
    .immediate_o(d64_imm), .err_cnt_o(d64_err_cnt)
  );

  always #5 clk = ~clk;

  // Advance one rising edge, then settle 1 time unit before checking/driving.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] w, input logic [31:0] p);
    in_valid = 1'b1;
    instr    = w;
    pc32     = p;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; instr = 32'hFFFF_FFFF; out_ready = 1'b1;
    tick(); tick();
    rst = 1'b0; in_valid = 1'b0;
    checks++; if (d32_out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid32: got %0b want 0", d32_out_valid); end
    checks++; if (d64_out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid64: got %0b want 0", d64_out_valid); end
    checks++; if (d32_in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %0b want 1", d32_in_ready); end
    checks++; if (d32_err_cnt !== 8'd0 || d64_err_cnt !== 8'd0) begin errors++; $display("FAIL reset_errcnt: got %0d/%0d want 0/0", d32_err_cnt, d64_err_cnt); end
    checks++; if (f32 !== 34'd0 || d32_imm !== 32'd0 || d32_pc !== 32'd0) begin errors++; $display("FAIL reset_head: got %h imm %h pc %h want 0", f32, d32_imm, d32_pc); end
    checks++; if (f64 !== 34'd0 || d64_imm !== 64'd0 || d64_pc !== 64'd0) begin errors++; $display("FAIL reset_head64: got %h imm %h pc %h want 0", f64, d64_imm, d64_pc); end
  endtask

  task automatic test_add();
    push(32'h00C5_8533, 32'h100);
    checks++; if (d32_out_valid !== 1'b1) begin errors++; $display("FAIL add_valid: got %0b want 1", d32_out_valid); end
    checks++; if (f32 !== {7'h33, 5'd11, 5'd12, 5'd10, 3'd0, 7'd0, 1'b1, 1'b0}) begin errors++; $display("FAIL add_fields32: got %h", f32); end
    checks++; if (f64 !== {7'h33, 5'd11, 5'd12, 5'd10, 3'd0, 7'd0, 1'b1, 1'b0}) begin errors++; $display("FAIL add_fields64: got %h", f64); end
    checks++; if (d32_pc !== 32'h100 || d32_imm !== 32'd0) begin errors++; $display("FAIL add_pc_imm: got pc %h imm %h want 100/0", d32_pc, d32_imm); end
    tick();
    checks++; if (d32_out_valid !== 1'b0) begin errors++; $display("FAIL add_popped: got %0b want 0", d32_out_valid); end
    push(32'h0000_0013, 32'h104);
    checks++; if (f32 !== {7'h13, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 1'b0, 1'b0}) begin errors++; $display("FAIL nop_rd0: got %h", f32); end
    tick();
  endtask

  task automatic test_immediates();
    push(32'hFFF0_0093, 32'h200);
    checks++; if (f32 !== {7'h13, 5'd0, 5'd0, 5'd1, 3'd0, 7'd0, 1'b1, 1'b0}) begin errors++; $display("FAIL addi_fields: got %h", f32); end
    checks++; if (d32_imm !== 32'hFFFF_FFFF) begin errors++; $display("FAIL addi_imm32: got %h want ffffffff", d32_imm); end
    checks++; if (d64_imm !== 64'hFFFF_FFFF_FFFF_FFFF || d64_rf_rw !== 1'b1) begin errors++; $display("FAIL addi_imm64: got %h rw %0b", d64_imm, d64_rf_rw); end
    tick();
    push(32'h8000_0537, 32'h204);
    checks++; if (f32 !== {7'h37, 5'd0, 5'd0, 5'd10, 3'd0, 7'd0, 1'b1, 1'b0}) begin errors++; $display("FAIL lui_fields: got %h", f32); end
    checks++; if (d32_imm !== 32'h8000_0000 || d64_imm !== 64'hFFFF_FFFF_8000_0000) begin errors++; $display("FAIL lui_imm: got %h / %h", d32_imm, d64_imm); end
    tick();
    push(32'h00B5_2223, 32'h208);
    checks++; if (f32 !== {7'h23, 5'd10, 5'd11, 5'd0, 3'd2, 7'd0, 1'b0, 1'b0}) begin errors++; $display("FAIL sw_fields: got %h", f32); end
    checks++; if (d32_imm !== 32'd4) begin errors++; $display("FAIL sw_imm: got %h want 4", d32_imm); end
    tick();
    push(32'h0080_00EF, 32'h20C);
    checks++; if (f32 !== {7'h6F, 5'd0, 5'd0, 5'd1, 3'd0, 7'd0, 1'b1, 1'b0}) begin errors++; $display("FAIL jal_fields: got %h", f32); end
    checks++; if (d32_imm !== 32'd8 || d64_imm !== 64'd8) begin errors++; $display("FAIL jal_imm: got %h / %h want 8", d32_imm, d64_imm); end
    tick();
  endtask

  task automatic test_branch();
    push(32'hFE00_0EE3, 32'h300);
    checks++; if (f32 !== {7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 1'b0, 1'b0}) begin errors++; $display("FAIL beq_fields: got %h", f32); end
    checks++; if (d32_imm !== 32'hFFFF_FFFC || d64_imm !== 64'hFFFF_FFFF_FFFF_FFFC) begin errors++; $display("FAIL beq_imm: got %h / %h want -4", d32_imm, d64_imm); end
    checks++; if (d32_err_cnt !== 8'd0) begin errors++; $display("FAIL beq_errcnt: got %0d want 0", d32_err_cnt); end
    tick();
    push(32'hFE00_2EE3, 32'h304);
    checks++; if (f32 !== {7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 1'b0, 1'b1}) begin errors++; $display("FAIL bad_br_fields: got %h", f32); end
    checks++; if (d32_imm !== 32'd0) begin errors++; $display("FAIL bad_br_imm: got %h want 0", d32_imm); end
    checks++; if (d32_err_cnt !== 8'd1 || d64_err_cnt !== 8'd1) begin errors++; $display("FAIL bad_br_errcnt: got %0d/%0d want 1/1", d32_err_cnt, d64_err_cnt); end
    tick();
  endtask

  task automatic test_mul();
    push(32'h02C5_8533, 32'h400);
    checks++; if (f32 !== {7'h33, 5'd11, 5'd12, 5'd10, 3'd0, 7'd1, 1'b1, 1'b0}) begin errors++; $display("FAIL mul_men1: got %h", f32); end
    checks++; if (f64 !== {7'h33, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 1'b0, 1'b1}) begin errors++; $display("FAIL mul_men0: got %h", f64); end
    checks++; if (d32_err_cnt !== 8'd1 || d64_err_cnt !== 8'd2) begin errors++; $display("FAIL mul_errcnt: got %0d/%0d want 1/2", d32_err_cnt, d64_err_cnt); end
    tick();
    push(32'h40C5_8533, 32'h404);
    checks++; if (d32_err !== 1'b1 || d32_rd !== 5'd0 || d32_funct7 !== 7'd0) begin errors++; $display("FAIL sub_illegal: got err %0b rd %0d f7 %h", d32_err, d32_rd, d32_funct7); end
    checks++; if (d32_err_cnt !== 8'd2 || d64_err_cnt !== 8'd3) begin errors++; $display("FAIL sub_errcnt: got %0d/%0d want 2/3", d32_err_cnt, d64_err_cnt); end
    tick();
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0;
    push(32'h00C5_8533, 32'h10);
    push(32'h00C5_8533, 32'h14);
    checks++; if (d32_in_ready !== 1'b0 || d64_in_ready !== 1'b0) begin errors++; $display("FAIL full_ready: got %0b/%0b want 0/0", d32_in_ready, d64_in_ready); end
    checks++; if (d32_pc !== 32'h10) begin errors++; $display("FAIL full_head: got %h want 10", d32_pc); end
    push(32'h00C5_8533, 32'h18);
    checks++; if (d32_pc !== 32'h10 || d32_in_ready !== 1'b0) begin errors++; $display("FAIL full_stall: got pc %h rdy %0b want 10/0", d32_pc, d32_in_ready); end
    out_ready = 1'b1;
    tick();
    checks++; if (d32_pc !== 32'h14 || d32_in_ready !== 1'b1) begin errors++; $display("FAIL pop_head: got pc %h rdy %0b want 14/1", d32_pc, d32_in_ready); end
    push(32'h00C5_8533, 32'h1C);
    checks++; if (d32_pc !== 32'h1C || d32_out_valid !== 1'b1 || d32_in_ready !== 1'b1) begin errors++; $display("FAIL wrap1: got pc %h v %0b r %0b want 1c/1/1", d32_pc, d32_out_valid, d32_in_ready); end
    push(32'h00C5_8533, 32'h20);
    checks++; if (d32_pc !== 32'h20 || d64_pc !== 64'hA5A5_A5A5_0000_0020) begin errors++; $display("FAIL wrap2: got %h / %h want 20", d32_pc, d64_pc); end
    tick();
    checks++; if (d32_out_valid !== 1'b0 || d32_pc !== 32'd0) begin errors++; $display("FAIL drain: got v %0b pc %h want 0/0", d32_out_valid, d32_pc); end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    push(32'hFFFF_FFFF, 32'h40);
    checks++; if (f32 !== {7'h7F, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 1'b0, 1'b1} || d32_imm !== 32'd0) begin errors++; $display("FAIL illegal_head: got %h imm %h", f32, d32_imm); end
    checks++; if (d32_err_cnt !== 8'd3 || d64_err_cnt !== 8'd4) begin errors++; $display("FAIL illegal_errcnt: got %0d/%0d want 3/4", d32_err_cnt, d64_err_cnt); end
    push(32'h00C5_8533, 32'h44);
    flush = 1'b1; in_valid = 1'b1; instr = 32'hFFFF_FFFF; out_ready = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    checks++; if (d32_out_valid !== 1'b0 || d32_in_ready !== 1'b1) begin errors++; $display("FAIL flush_empty: got v %0b r %0b want 0/1", d32_out_valid, d32_in_ready); end
    checks++; if (d32_err_cnt !== 8'd3 || d64_err_cnt !== 8'd4) begin errors++; $display("FAIL flush_errcnt: got %0d/%0d want 3/4", d32_err_cnt, d64_err_cnt); end
    push(32'h00C5_8533, 32'h48);
    checks++; if (d32_out_valid !== 1'b1 || d32_pc !== 32'h48) begin errors++; $display("FAIL post_flush: got v %0b pc %h want 1/48", d32_out_valid, d32_pc); end
    tick();
  endtask

  task automatic test_saturate();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    instr     = 32'hFFFF_FFFF;
    for (int i = 0; i < 251; i++) tick();
    checks++; if (d32_err_cnt !== 8'd254 || d64_err_cnt !== 8'd255) begin errors++; $display("FAIL sat_pre: got %0d/%0d want 254/255", d32_err_cnt, d64_err_cnt); end
    for (int i = 0; i < 5; i++) tick();
    in_valid = 1'b0;
    checks++; if (d32_err_cnt !== 8'd255 || d64_err_cnt !== 8'd255) begin errors++; $display("FAIL sat_hold: got %0d/%0d want 255/255", d32_err_cnt, d64_err_cnt); end
    checks++; if (d32_out_valid !== 1'b1 || d32_err !== 1'b1) begin errors++; $display("FAIL sat_head: got v %0b err %0b want 1/1", d32_out_valid, d32_err); end
    tick();
  endtask

  initial begin
    #1;
    test_reset();
    test_add();
    test_immediates();
    test_branch();
    test_mul();
    test_back_to_back();
    test_flush();
    test_saturate();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
